// File: rtl/keypad_entry_ctrl.sv
// keypad_entry_ctrl: debounces per-scan keypad samples, strobes once per press and
// assembles BCD digit entries. Define KEYPAD_AUTOREPEAT_EN to add held-key auto-repeat.
module keypad_entry_ctrl #(
  parameter int DIGITS          = 4,
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int CNT_W           = 8
`ifdef KEYPAD_AUTOREPEAT_EN
  ,parameter int REPEAT_SAMPLES = 500
`endif
) (
  input  logic                clock_100Mhz,
  input  logic                reset,
  input  logic                sample_valid,
  input  logic                key_down,
  input  logic [3:0]          key_code,
  output logic                key_strobe,
  output logic [3:0]          key_last,
  output logic [4*DIGITS-1:0] entry,
  output logic [3:0]          digit_count,
  output logic                entry_valid,
  output logic [4*DIGITS-1:0] entry_value,
  output logic                overflow
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PRESS = 2'd1;
  localparam logic [1:0] S_HELD  = 2'd2;
  localparam logic [1:0] S_REL   = 2'd3;

  localparam logic [CNT_W-1:0] L_DB     = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] L_ONE    = CNT_W'(1);
  localparam logic [3:0]       L_DIGITS = 4'(DIGITS);

  logic [1:0]          r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [3:0]          r_cand, w_cand_nxt;
  logic                w_accept, w_fire;
  logic                r_strobe, r_valid, r_ovf;
  logic [3:0]          r_last, r_count;
  logic [4*DIGITS-1:0] r_entry, r_value;

  assign w_cnt_inc = r_cnt + L_ONE;

  // Debounce sequencing; only sample_valid cycles move the FSM.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cand_nxt  = r_cand;
    w_accept    = 1'b0;
    if (sample_valid) begin
      case (r_state)
        S_IDLE: if (key_down) begin
          w_cand_nxt = key_code;
          w_cnt_nxt  = L_ONE;
          if (DEBOUNCE_CYCLES <= 1) begin
            w_accept    = 1'b1;
            w_state_nxt = S_HELD;
          end else begin
            w_state_nxt = S_PRESS;
          end
        end
        S_PRESS: if (key_down && key_code == r_cand) begin
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc >= L_DB) begin
            w_accept    = 1'b1;
            w_state_nxt = S_HELD;
          end
        end else begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
        end
        S_HELD: if (!key_down) begin
          w_cnt_nxt   = L_ONE;
          w_state_nxt = (DEBOUNCE_CYCLES <= 1) ? S_IDLE : S_REL;
        end
        S_REL: if (!key_down) begin
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc >= L_DB) begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_state_nxt = S_HELD;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int L_RPT_NEXT = (REPEAT_SAMPLES / 4 > 0) ? REPEAT_SAMPLES / 4 : 1;
  logic [31:0] r_rpt, w_rpt_target;
  logic        r_rpt_armed, w_rpt_hit;

  assign w_rpt_target = r_rpt_armed ? 32'(L_RPT_NEXT) : 32'(REPEAT_SAMPLES);
  assign w_rpt_hit    = sample_valid && key_down && (r_state == S_HELD) &&
                        (r_rpt + 32'd1 >= w_rpt_target);
  assign w_fire       = w_accept || (w_rpt_hit && (r_cand <= 4'd9 || r_cand == 4'hD));

  // Counter sits at zero outside HELD, so every entry into HELD starts fresh.
  always_ff @(posedge clock_100Mhz) begin
    if (reset || r_state != S_HELD) begin
      r_rpt       <= '0;
      r_rpt_armed <= 1'b0;
    end else if (sample_valid && key_down) begin
      if (w_rpt_hit) begin
        r_rpt       <= '0;
        r_rpt_armed <= 1'b1;
      end else begin
        r_rpt <= r_rpt + 32'd1;
      end
    end
  end
`else
  assign w_fire = w_accept;
`endif

  always_ff @(posedge clock_100Mhz) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_cand   <= '0;
      r_strobe <= 1'b0;
      r_valid  <= 1'b0;
      r_ovf    <= 1'b0;
      r_last   <= '0;
      r_count  <= '0;
      r_entry  <= '0;
      r_value  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_cand   <= w_cand_nxt;
      r_strobe <= w_fire;
      r_valid  <= 1'b0;
      r_ovf    <= 1'b0;
      if (w_fire) begin
        r_last <= w_cand_nxt;
        case (w_cand_nxt)
          4'hF: begin
            r_value <= r_entry;
            r_valid <= 1'b1;
            r_entry <= '0;
            r_count <= '0;
          end
          4'hE: begin
            r_entry <= '0;
            r_count <= '0;
          end
          4'hD: if (r_count != 4'd0) begin
            r_entry <= r_entry >> 4;
            r_count <= r_count - 4'd1;
          end
          4'hA, 4'hB, 4'hC: ;
          default: if (r_count < L_DIGITS) begin
            r_entry <= (r_entry << 4) | (4*DIGITS)'(w_cand_nxt);
            r_count <= r_count + 4'd1;
          end else begin
            r_ovf <= 1'b1;
          end
        endcase
      end
    end
  end

  assign key_strobe  = r_strobe;
  assign key_last    = r_last;
  assign entry       = r_entry;
  assign digit_count = r_count;
  assign entry_valid = r_valid;
  assign entry_value = r_value;
  assign overflow    = r_ovf;
endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Bench for keypad_entry_ctrl: directed scenarios plus randomized press streams,
// compared every cycle against a press/release run-length and digit-queue model.
module tb_keypad_entry_ctrl;
  localparam int DIGITS = 4;
  localparam int DB     = 3;

  logic clock_100Mhz = 1'b0;
  logic reset, sample_valid, key_down;
  logic [3:0] key_code;
  logic key_strobe, entry_valid, overflow;
  logic [3:0] key_last, digit_count;
  logic [15:0] entry, entry_value;

  keypad_entry_ctrl #(.DIGITS(DIGITS), .DEBOUNCE_CYCLES(DB), .CNT_W(8)) dut (
    .clock_100Mhz(clock_100Mhz), .reset(reset), .sample_valid(sample_valid),
    .key_down(key_down), .key_code(key_code), .key_strobe(key_strobe),
    .key_last(key_last), .entry(entry), .digit_count(digit_count),
    .entry_valid(entry_valid), .entry_value(entry_value), .overflow(overflow));

  always #5 clock_100Mhz = ~clock_100Mhz;

  wire [42:0] w_dut = {key_strobe, key_last, entry, digit_count, entry_valid, entry_value, overflow};

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed { logic r; logic sv; logic kd; logic [3:0] kc; } smp_t;
  smp_t s_q[$];

  // Reference model: run lengths of matching samples and a queue of digits.
  int         m_run, m_uprun;
  bit         m_held;
  logic [3:0] m_cand;
  logic [3:0] m_dig[$];
  logic       e_strobe, e_valid, e_ovf;
  logic [3:0] e_last;
  logic [15:0] e_value;

  function automatic logic [15:0] m_entry();
    logic [15:0] e = '0;
    foreach (m_dig[i]) e = {e[11:0], m_dig[i]};
    return e;
  endfunction

  function automatic logic [42:0] exp_vec();
    return {e_strobe, e_last, m_entry(), 4'(m_dig.size()), e_valid, e_value, e_ovf};
  endfunction

  task automatic model_reset();
    m_run = 0; m_uprun = 0; m_held = 0; m_cand = '0;
    m_dig.delete();
    e_last = '0; e_value = '0;
  endtask

  task automatic model_accept(input logic [3:0] c);
    e_strobe = 1'b1;
    e_last   = c;
    if (c <= 4'd9) begin
      if (m_dig.size() < DIGITS) m_dig.push_back(c);
      else e_ovf = 1'b1;
    end else if (c == 4'hF) begin
      e_value = m_entry(); e_valid = 1'b1; m_dig.delete();
    end else if (c == 4'hE) begin
      m_dig.delete();
    end else if (c == 4'hD) begin
      if (m_dig.size() > 0) void'(m_dig.pop_back());
    end
  endtask

  task automatic model_sample(input logic kd, input logic [3:0] kc);
    if (!m_held) begin
      if (kd) begin
        if (m_run == 0) begin m_cand = kc; m_run = 1; end
        else if (kc == m_cand) m_run++;
        else m_run = 0;
        if (m_run >= DB) begin model_accept(m_cand); m_held = 1; m_run = 0; m_uprun = 0; end
      end else m_run = 0;
    end else begin
      if (!kd) begin
        m_uprun++;
        if (m_uprun >= DB) begin m_held = 0; m_uprun = 0; end
      end else m_uprun = 0;
    end
  endtask

  task automatic step(input logic r, input logic sv, input logic kd, input logic [3:0] kc);
    reset = r; sample_valid = sv; key_down = kd; key_code = kc;
    e_strobe = 1'b0; e_valid = 1'b0; e_ovf = 1'b0;
    if (r) model_reset();
    else if (sv) model_sample(kd, kc);
    @(posedge clock_100Mhz);
    #1;
  endtask

  task automatic add_smp(input logic r, input logic sv, input logic kd, input logic [3:0] kc);
    smp_t s;
    s.r = r; s.sv = sv; s.kd = kd; s.kc = kc;
    s_q.push_back(s);
  endtask

  task automatic add_gap(input int gmax);
    int n = int'($urandom_range(gmax, 0));
    for (int g = 0; g < n; g++) add_smp(1'b0, 1'b0, 1'($urandom_range(1, 0)), 4'($urandom));
  endtask

  task automatic add_press(input logic [3:0] c, input int dn, input int up, input int gmax);
    for (int k = 0; k < dn; k++) begin add_smp(1'b0, 1'b1, 1'b1, c); add_gap(gmax); end
    for (int k = 0; k < up; k++) begin add_smp(1'b0, 1'b1, 1'b0, 4'($urandom)); add_gap(gmax); end
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, 1'b1, 4'h5);
    step(1'b1, 1'b0, 1'b0, 4'h0);
    n_vec++;
    if (w_dut !== 43'h0) begin n_err++; $display("FAIL reset_outputs got %h want 0", w_dut); end
    n_vec++;
    if (w_dut !== exp_vec()) begin n_err++; $display("FAIL reset_model got %h want %h", w_dut, exp_vec()); end
  endtask

  task automatic test_single_press();
    int strobes = 0;
    step(1'b1, 1'b0, 1'b0, 4'h0);
    add_press(4'h5, DB, DB, 2);
    foreach (s_q[i]) begin
      step(s_q[i].r, s_q[i].sv, s_q[i].kd, s_q[i].kc);
      n_vec++;
      if (w_dut !== exp_vec()) begin n_err++; $display("FAIL single_press[%0d] got %h want %h", i, w_dut, exp_vec()); end
      if (key_strobe) strobes++;
    end
    s_q.delete();
    n_vec++;
    if (strobes != 1 || key_last !== 4'h5 || entry !== 16'h0005 || digit_count !== 4'd1) begin
      n_err++;
      $display("FAIL single_press_final strobes=%0d last=%h entry=%h cnt=%0d want 1/5/0005/1", strobes, key_last, entry, digit_count);
    end
  endtask

  task automatic test_bounce();
    int strobes = 0;
    int sidx = -1;
    step(1'b1, 1'b0, 1'b0, 4'h0);
    add_press(4'h7, 2, 1, 0);
    add_press(4'h7, 3, DB, 0);
    foreach (s_q[i]) begin
      step(s_q[i].r, s_q[i].sv, s_q[i].kd, s_q[i].kc);
      n_vec++;
      if (w_dut !== exp_vec()) begin n_err++; $display("FAIL bounce[%0d] got %h want %h", i, w_dut, exp_vec()); end
      if (key_strobe) begin strobes++; sidx = i; end
    end
    s_q.delete();
    n_vec++;
    if (strobes != 1 || sidx != 5 || entry[3:0] !== 4'h7) begin
      n_err++;
      $display("FAIL bounce_final strobes=%0d at=%0d lsd=%h want 1/5/7", strobes, sidx, entry[3:0]);
    end
  endtask

  task automatic test_overflow_enter();
    int ovf = 0;
    int vld = 0;
    int both = 0;
    step(1'b1, 1'b0, 1'b0, 4'h0);
    for (int k = 1; k <= 5; k++) add_press(4'(k), DB, DB, 1);
    add_press(4'hF, DB, DB, 1);
    foreach (s_q[i]) begin
      step(s_q[i].r, s_q[i].sv, s_q[i].kd, s_q[i].kc);
      n_vec++;
      if (w_dut !== exp_vec()) begin n_err++; $display("FAIL overflow_enter[%0d] got %h want %h", i, w_dut, exp_vec()); end
      if (overflow) ovf++;
      if (entry_valid) vld++;
      if ((overflow || entry_valid) && key_strobe) both++;
    end
    s_q.delete();
    n_vec++;
    if (ovf != 1 || vld != 1 || both != 2 || entry_value !== 16'h1234 || entry !== 16'h0 || digit_count !== 4'd0) begin
      n_err++;
      $display("FAIL overflow_enter_final ovf=%0d vld=%0d coinc=%0d value=%h entry=%h cnt=%0d want 1/1/2/1234/0/0",
               ovf, vld, both, entry_value, entry, digit_count);
    end
  endtask

  task automatic test_backspace_clear();
    int vld = 0;
    step(1'b1, 1'b0, 1'b0, 4'h0);
    add_press(4'h9, DB, DB, 1);
    add_press(4'h8, DB, DB, 1);
    add_press(4'hD, DB, DB, 1);
    add_press(4'hF, DB, DB, 1);
    add_press(4'hE, DB, DB, 1);
    add_press(4'hD, DB, DB, 1);
    foreach (s_q[i]) begin
      step(s_q[i].r, s_q[i].sv, s_q[i].kd, s_q[i].kc);
      n_vec++;
      if (w_dut !== exp_vec()) begin n_err++; $display("FAIL backspace_clear[%0d] got %h want %h", i, w_dut, exp_vec()); end
      if (entry_valid) vld++;
    end
    s_q.delete();
    n_vec++;
    if (vld != 1 || entry_value !== 16'h0009 || entry !== 16'h0 || digit_count !== 4'd0 || key_last !== 4'hD) begin
      n_err++;
      $display("FAIL backspace_clear_final vld=%0d value=%h entry=%h cnt=%0d last=%h want 1/0009/0/0/D",
               vld, entry_value, entry, digit_count, key_last);
    end
  endtask

  task automatic test_reset_mid_press();
    int strobes = 0;
    step(1'b1, 1'b0, 1'b0, 4'h0);
    add_smp(1'b0, 1'b1, 1'b1, 4'h3);
    add_smp(1'b0, 1'b1, 1'b1, 4'h3);
    add_smp(1'b1, 1'b1, 1'b1, 4'h3);
    add_smp(1'b0, 1'b1, 1'b1, 4'h3);
    for (int k = 0; k < 4; k++) add_smp(1'b0, 1'b1, 1'b0, 4'h0);
    for (int k = 0; k < 30; k++) add_smp(1'b0, 1'b0, 1'b1, 4'h6);
    add_smp(1'b0, 1'b1, 1'b0, 4'h0);
    foreach (s_q[i]) begin
      step(s_q[i].r, s_q[i].sv, s_q[i].kd, s_q[i].kc);
      n_vec++;
      if (w_dut !== exp_vec()) begin n_err++; $display("FAIL reset_mid_press[%0d] got %h want %h", i, w_dut, exp_vec()); end
      if (key_strobe) strobes++;
    end
    s_q.delete();
    n_vec++;
    if (strobes != 0 || w_dut !== 43'h0) begin
      n_err++;
      $display("FAIL reset_mid_press_final strobes=%0d outs=%h want 0/0", strobes, w_dut);
    end
  endtask

  task automatic test_back_to_back();
    int vld = 0;
    step(1'b1, 1'b0, 1'b0, 4'h0);
    add_press(4'h1, DB, DB, 0);
    add_press(4'h2, DB, DB, 0);
    add_press(4'h3, DB, DB, 0);
    add_press(4'hF, DB, DB, 0);
    foreach (s_q[i]) begin
      step(s_q[i].r, s_q[i].sv, s_q[i].kd, s_q[i].kc);
      n_vec++;
      if (w_dut !== exp_vec()) begin n_err++; $display("FAIL back_to_back[%0d] got %h want %h", i, w_dut, exp_vec()); end
      if (entry_valid) vld++;
    end
    s_q.delete();
    n_vec++;
    if (vld != 1 || entry_value !== 16'h0123) begin
      n_err++;
      $display("FAIL back_to_back_final vld=%0d value=%h want 1/0123", vld, entry_value);
    end
  endtask

  task automatic test_random();
    logic [3:0] c;
    step(1'b1, 1'b0, 1'b0, 4'h0);
    for (int p = 0; p < 60; p++) begin
      c = 4'($urandom);
      for (int k = 0; k < int'($urandom_range(5, 1)); k++) begin
        if ($urandom_range(5, 0) == 0) c = 4'($urandom);
        add_smp(1'b0, 1'b1, 1'b1, c);
        add_gap(2);
      end
      for (int k = 0; k < int'($urandom_range(4, 1)); k++) begin
        add_smp(1'b0, 1'b1, 1'($urandom_range(4, 0) == 0), 4'($urandom));
        add_gap(2);
      end
      if ($urandom_range(24, 0) == 0) add_smp(1'b1, 1'($urandom), 1'($urandom), 4'($urandom));
    end
    foreach (s_q[i]) begin
      step(s_q[i].r, s_q[i].sv, s_q[i].kd, s_q[i].kc);
      n_vec++;
      if (w_dut !== exp_vec()) begin n_err++; $display("FAIL random[%0d] got %h want %h", i, w_dut, exp_vec()); end
    end
    s_q.delete();
  endtask

  initial begin
    reset = 1'b1; sample_valid = 1'b0; key_down = 1'b0; key_code = 4'h0;
    model_reset();
    e_strobe = 1'b0; e_valid = 1'b0; e_ovf = 1'b0;
    test_reset();
    test_single_press();
    test_bounce();
    test_overflow_enter();
    test_backspace_clear();
    test_reset_mid_press();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
